// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe: decode-to-execute stage of the 24-bit core.
// Holds the register file (with same-cycle writeback bypass), extends the
// immediate, detects load-use hazards and inserts a bubble for them, and
// carries the decoded instruction into execute through a valid/ready
// pipeline register that a taken branch can flush.
module decode_stage_pipe #(
    parameter int DATA_W       = 24,
    parameter int INSTR_W      = 38,
    parameter int PC_W         = 24,
    parameter int REG_AW       = 4,
    parameter int CTRL_W       = 8,
    parameter int RS1_LSB      = 28,
    parameter int RS2_LSB      = 24,
    parameter int RD_LSB       = 0,
    parameter int IMM_LSB      = 8,
    parameter int IMM_W        = 16,
    parameter int REGWRITE_BIT = 0,
    parameter int MEMREAD_BIT  = 1,
    parameter bit R0_ZERO      = 1'b1,
    parameter int CNT_W        = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr_d,
    input  logic [PC_W-1:0]    pc_d,
    input  logic [PC_W-1:0]    pcplus4_d,
    input  logic [CTRL_W-1:0]  ctrl_d,
    input  logic               imm_signed,
    input  logic               wb_we,
    input  logic [REG_AW-1:0]  wb_addr,
    input  logic [DATA_W-1:0]  wb_data,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CTRL_W-1:0]  ctrl_e,
    output logic [DATA_W-1:0]  rd1_e,
    output logic [DATA_W-1:0]  rd2_e,
    output logic [DATA_W-1:0]  imm_e,
    output logic [REG_AW-1:0]  rs1_e,
    output logic [REG_AW-1:0]  rs2_e,
    output logic [REG_AW-1:0]  rd_e,
    output logic [PC_W-1:0]    pc_e,
    output logic [PC_W-1:0]    pcplus4_e,
    output logic               hazard_o,
    output logic [CNT_W-1:0]   stall_cnt
);

    localparam int NREGS = 2 ** REG_AW;
    // Bits of the extended immediate that come straight from the field.
    localparam logic [DATA_W-1:0] IMM_MASK = DATA_W'({IMM_W{1'b1}});

    // Everything the execute stage receives alongside out_valid.
    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [PC_W-1:0]   pc;
        logic [PC_W-1:0]   pcplus4;
    } e_entry_t;

    logic [DATA_W-1:0] rf_q [NREGS];

    logic [REG_AW-1:0] rs1_d;
    logic [REG_AW-1:0] rs2_d;
    logic [REG_AW-1:0] rd_d;
    logic [IMM_W-1:0]  imm_raw;
    logic [DATA_W-1:0] imm_d;
    logic [DATA_W-1:0] rd1_d;
    logic [DATA_W-1:0] rd2_d;

    e_entry_t          e_q;
    e_entry_t          e_d;
    logic              valid_q;
    logic              valid_d;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  stall_cnt_d;

    logic              load_in_e;
    logic              rd_e_live;
    logic              rd_e_match;
    logic              hazard;
    logic              instr_unused;

    // Field extraction; bits outside the decoded fields are don't-care here.
    assign rs1_d        = instr_d[RS1_LSB +: REG_AW];
    assign rs2_d        = instr_d[RS2_LSB +: REG_AW];
    assign rd_d         = instr_d[RD_LSB +: REG_AW];
    assign imm_raw      = instr_d[IMM_LSB +: IMM_W];
    assign instr_unused = ^instr_d;

    // Sign extension fills every bit above the field with the field's MSB.
    assign imm_d = DATA_W'(imm_raw)
                 | ((imm_signed && imm_raw[IMM_W-1]) ? ~IMM_MASK : '0);

    // Register-file reads with same-cycle writeback bypass.
    always_comb begin
        // NOTE: each always_comb output is given a default first so that no path leaves it unassigned and infers a latch.
        rd1_d = rf_q[rs1_d];
        rd2_d = rf_q[rs2_d];
        if (wb_we && (wb_addr == rs1_d) && !(R0_ZERO && (rs1_d == '0))) begin
            rd1_d = wb_data;
        end
        if (wb_we && (wb_addr == rs2_d) && !(R0_ZERO && (rs2_d == '0))) begin
            rd2_d = wb_data;
        end
    end

    // Register-file storage; register 0 stays zero when hard-wired.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the register file is cleared by reset so reads after reset are defined as 0; this rules out mapping it onto a RAM macro.
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_we && !(R0_ZERO && (wb_addr == '0))) begin
            rf_q[wb_addr] <= wb_data;
        end
    end

    // Load-use hazard: the load in E has not produced its data yet, so a
    // dependent instruction in D must wait one bubble. A flush kills both
    // sides, so it overrides the stall.
    assign load_in_e  = valid_q && e_q.ctrl[MEMREAD_BIT] && e_q.ctrl[REGWRITE_BIT];
    assign rd_e_live  = !R0_ZERO || (e_q.rd != '0);
    assign rd_e_match = (e_q.rd == rs1_d) || (e_q.rd == rs2_d);
    assign hazard     = in_valid && load_in_e && rd_e_live && rd_e_match && !flush;

    assign in_ready = flush || (!hazard && (!valid_q || out_ready));

    // Next E contents: flush, bubble, hold, load, or drain, in that priority.
    always_comb begin
        e_d     = e_q;
        valid_d = valid_q;
        if (flush || (hazard && out_ready)) begin
            valid_d = 1'b0;
            e_d.ctrl = '0;
        end else if (valid_q && !out_ready) begin
            e_d     = e_q;
            valid_d = 1'b1;
        end else if (in_valid && in_ready) begin
            valid_d     = 1'b1;
            e_d.ctrl    = ctrl_d;
            e_d.rd1     = rd1_d;
            e_d.rd2     = rd2_d;
            e_d.imm     = imm_d;
            e_d.rs1     = rs1_d;
            e_d.rs2     = rs2_d;
            e_d.rd      = rd_d;
            e_d.pc      = pc_d;
            e_d.pcplus4 = pcplus4_d;
        end else begin
            valid_d  = 1'b0;
            e_d.ctrl = '0;
        end
    end

    // Saturating count of cycles spent stalled on a load-use hazard.
    assign stall_cnt_d = (hazard && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1)
                                                         : stall_cnt_q;

    // D->E pipeline register and stall counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= 1'b0;
            e_q         <= '0;
            stall_cnt_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values regardless of statement order.
            valid_q     <= valid_d;
            e_q         <= e_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign ctrl_e    = e_q.ctrl;
    assign rd1_e     = e_q.rd1;
    assign rd2_e     = e_q.rd2;
    assign imm_e     = e_q.imm;
    assign rs1_e     = e_q.rs1;
    assign rs2_e     = e_q.rs2;
    assign rd_e      = e_q.rd;
    assign pc_e      = e_q.pc;
    assign pcplus4_e = e_q.pcplus4;
    assign hazard_o  = hazard;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Self-checking bench for decode_stage_pipe: directed steps from the test
// plan followed by a randomized phase, all compared against a transaction
// level model of the stage kept in this file.
module tb_decode_stage_pipe;

    localparam int DATA_W  = 24;
    localparam int INSTR_W = 38;
    localparam int PC_W    = 24;
    localparam int REG_AW  = 4;
    localparam int CTRL_W  = 8;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] instr_d;
    logic [PC_W-1:0]    pc_d;
    logic [PC_W-1:0]    pcplus4_d;
    logic [CTRL_W-1:0]  ctrl_d;
    logic               imm_signed;
    logic               wb_we;
    logic [REG_AW-1:0]  wb_addr;
    logic [DATA_W-1:0]  wb_data;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [CTRL_W-1:0]  ctrl_e;
    logic [DATA_W-1:0]  rd1_e;
    logic [DATA_W-1:0]  rd2_e;
    logic [DATA_W-1:0]  imm_e;
    logic [REG_AW-1:0]  rs1_e;
    logic [REG_AW-1:0]  rs2_e;
    logic [REG_AW-1:0]  rd_e;
    logic [PC_W-1:0]    pc_e;
    logic [PC_W-1:0]    pcplus4_e;
    logic               hazard_o;
    logic [CNT_W-1:0]   stall_cnt;

    always #5 clk = ~clk;

    decode_stage_pipe #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instr_d    (instr_d),
        .pc_d       (pc_d),
        .pcplus4_d  (pcplus4_d),
        .ctrl_d     (ctrl_d),
        .imm_signed (imm_signed),
        .wb_we      (wb_we),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ctrl_e     (ctrl_e),
        .rd1_e      (rd1_e),
        .rd2_e      (rd2_e),
        .imm_e      (imm_e),
        .rs1_e      (rs1_e),
        .rs2_e      (rs2_e),
        .rd_e       (rd_e),
        .pc_e       (pc_e),
        .pcplus4_e  (pcplus4_e),
        .hazard_o   (hazard_o),
        .stall_cnt  (stall_cnt)
    );

    // ---------------- reference model ----------------
    typedef struct {
        bit          v;
        logic [7:0]  ctrl;
        logic [23:0] rd1;
        logic [23:0] rd2;
        logic [23:0] imm;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [3:0]  rd;
        logic [23:0] pc;
        logic [23:0] pc4;
    } e_t;

    e_t          m_e;
    logic [23:0] m_rf [16];
    int          m_cnt;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic m_reset();
        m_e = '{default: '0};
        for (int i = 0; i < 16; i++) m_rf[i] = '0;
        m_cnt = 0;
    endtask

    // Architectural read as seen by D: r0 is zero, a concurrent write wins.
    function automatic logic [23:0] m_read(input logic [3:0] a);
        if (a == 4'd0) return 24'd0;
        if (wb_we && wb_addr == a) return wb_data;
        return m_rf[a];
    endfunction

    function automatic logic [23:0] m_imm();
        logic [15:0] f;
        f = instr_d[8 +: 16];
        if (imm_signed && f[15]) return 24'(f) - 24'h010000;
        return 24'(f);
    endfunction

    function automatic bit m_hazard();
        logic [3:0] s1;
        logic [3:0] s2;
        s1 = instr_d[28 +: 4];
        s2 = instr_d[24 +: 4];
        return in_valid && m_e.v && m_e.ctrl[1] && m_e.ctrl[0] && (m_e.rd != 4'd0)
               && (m_e.rd == s1 || m_e.rd == s2) && !flush;
    endfunction

    function automatic bit m_ready();
        return flush || (!m_hazard() && (!m_e.v || out_ready));
    endfunction

    task automatic m_clock();
        bit h;
        bit r;
        h = m_hazard();
        r = m_ready();
        if (h && m_cnt < CNT_MAX) m_cnt++;
        if (flush || (h && out_ready)) begin
            m_e.v    = 1'b0;
            m_e.ctrl = '0;
        end else if (m_e.v && !out_ready) begin
            m_e.v = 1'b1;
        end else if (in_valid && r) begin
            m_e.v    = 1'b1;
            m_e.ctrl = ctrl_d;
            m_e.rd1  = m_read(instr_d[28 +: 4]);
            m_e.rd2  = m_read(instr_d[24 +: 4]);
            m_e.imm  = m_imm();
            m_e.rs1  = instr_d[28 +: 4];
            m_e.rs2  = instr_d[24 +: 4];
            m_e.rd   = instr_d[0 +: 4];
            m_e.pc   = pc_d;
            m_e.pc4  = pcplus4_d;
        end else begin
            m_e.v    = 1'b0;
            m_e.ctrl = '0;
        end
        if (wb_we && wb_addr != 4'd0) m_rf[wb_addr] = wb_data;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("out_valid", 64'(out_valid), 64'(m_e.v));
        check("ctrl_e",    64'(ctrl_e),    64'(m_e.ctrl));
        check("rd1_e",     64'(rd1_e),     64'(m_e.rd1));
        check("rd2_e",     64'(rd2_e),     64'(m_e.rd2));
        check("imm_e",     64'(imm_e),     64'(m_e.imm));
        check("rs1_e",     64'(rs1_e),     64'(m_e.rs1));
        check("rs2_e",     64'(rs2_e),     64'(m_e.rs2));
        check("rd_e",      64'(rd_e),      64'(m_e.rd));
        check("pc_e",      64'(pc_e),      64'(m_e.pc));
        check("pcplus4_e", 64'(pcplus4_e), 64'(m_e.pc4));
        check("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
        check("hazard_o",  64'(hazard_o),  64'(m_hazard()));
        check("in_ready",  64'(in_ready),  64'(m_ready()));
    endtask

    // Compare mid-cycle, away from the active edge.
    task automatic settle();
        @(negedge clk);
        check_all();
    endtask

    // Advance one edge and keep the model in step.
    task automatic tick();
        @(posedge clk);
        if (rst) m_reset();
        else m_clock();
        #1;
    endtask

    task automatic step();
        settle();
        tick();
    endtask

    // ---------------- stimulus helpers ----------------
    function automatic logic [37:0] mk_instr(input logic [3:0] s1, input logic [3:0] s2,
                                             input logic [3:0] d, input logic [15:0] imm);
        logic [37:0] x;
        x = '0;
        x[28 +: 4] = s1;
        x[24 +: 4] = s2;
        x[0 +: 4]  = d;
        x[8 +: 16] = imm;
        x[37:32]   = 6'h2A;
        return x;
    endfunction

    task automatic idle();
        in_valid   = 1'b0;
        instr_d    = '0;
        pc_d       = '0;
        pcplus4_d  = '0;
        ctrl_d     = '0;
        imm_signed = 1'b0;
        wb_we      = 1'b0;
        wb_addr    = '0;
        wb_data    = '0;
        flush      = 1'b0;
        out_ready  = 1'b1;
    endtask

    task automatic dec(input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] d,
                       input logic [15:0] imm, input logic [7:0] ctrl, input logic [23:0] pc);
        in_valid  = 1'b1;
        instr_d   = mk_instr(s1, s2, d, imm);
        ctrl_d    = ctrl;
        pc_d      = pc;
        pcplus4_d = pc + 24'd4;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with busy inputs: everything reads zero, in_ready high.
        rst = 1'b1;
        idle();
        dec(4'd3, 4'd5, 4'd7, 16'hFFFF, 8'h03, 24'h000AA0);
        wb_we = 1'b1; wb_addr = 4'd3; wb_data = 24'h777777;
        m_reset();
        #1;
        repeat (3) begin
            settle();
            check("rst_in_ready", 64'(in_ready), 64'h1);
            check("rst_out_valid", 64'(out_valid), 64'h0);
            check("rst_rd1_e", 64'(rd1_e), 64'h0);
            tick();
        end
        rst = 1'b0;
        idle();

        // Write r3, then decode rs1=3 with a negative immediate.
        wb_we = 1'b1; wb_addr = 4'd3; wb_data = 24'h00ABCD;
        step();
        idle();
        dec(4'd3, 4'd0, 4'd1, 16'h8001, 8'h01, 24'h000100);
        imm_signed = 1'b1;
        step();
        check("rf_write_rd1", 64'(rd1_e), 64'h00ABCD);
        check("imm_sext", 64'(imm_e), 64'hFF8001);
        check("accept_valid", 64'(out_valid), 64'h1);

        // Same-cycle bypass on rs2, zero-extended immediate.
        dec(4'd0, 4'd5, 4'd1, 16'h8001, 8'h01, 24'h000104);
        imm_signed = 1'b0;
        wb_we = 1'b1; wb_addr = 4'd5; wb_data = 24'h123456;
        step();
        check("bypass_rd2", 64'(rd2_e), 64'h123456);
        check("imm_zext", 64'(imm_e), 64'h008001);

        // Write and read of r0 together, then a stored read of r0.
        dec(4'd0, 4'd0, 4'd1, 16'h0000, 8'h01, 24'h000108);
        wb_we = 1'b1; wb_addr = 4'd0; wb_data = 24'hFFFFFF;
        step();
        check("r0_bypass_rd1", 64'(rd1_e), 64'h0);
        wb_we = 1'b0;
        step();
        check("r0_stored_rd1", 64'(rd1_e), 64'h0);

        // Load to r7, then a consumer of r7: one bubble, then issue.
        dec(4'd1, 4'd2, 4'd7, 16'h0000, 8'h03, 24'h00010C);
        step();
        check("load_rd_e", 64'(rd_e), 64'h7);
        dec(4'd7, 4'd3, 4'd2, 16'h0000, 8'h01, 24'h000200);
        settle();
        check("lu_hazard", 64'(hazard_o), 64'h1);
        check("lu_in_ready", 64'(in_ready), 64'h0);
        tick();
        check("bubble_valid", 64'(out_valid), 64'h0);
        check("bubble_ctrl", 64'(ctrl_e), 64'h0);
        check("lu_stall_cnt", 64'(stall_cnt), 64'h1);
        settle();
        check("lu_release_ready", 64'(in_ready), 64'h1);
        tick();
        check("lu_issue_pc", 64'(pc_e), 64'h000200);
        check("lu_issue_valid", 64'(out_valid), 64'h1);

        // Backpressure: E holds, D waits.
        dec(4'd4, 4'd4, 4'd5, 16'h0000, 8'h01, 24'h000300);
        out_ready = 1'b0;
        repeat (3) begin
            settle();
            check("bp_in_ready", 64'(in_ready), 64'h0);
            tick();
            check("bp_hold_pc", 64'(pc_e), 64'h000200);
            check("bp_hold_valid", 64'(out_valid), 64'h1);
        end
        out_ready = 1'b1;
        step();
        check("bp_release_pc", 64'(pc_e), 64'h000300);

        // Flush: the presented instruction is dropped.
        dec(4'd1, 4'd1, 4'd6, 16'h0000, 8'h01, 24'h000400);
        flush = 1'b1;
        settle();
        check("flush_in_ready", 64'(in_ready), 64'h1);
        tick();
        check("flush_valid", 64'(out_valid), 64'h0);
        flush = 1'b0;
        dec(4'd1, 4'd1, 4'd6, 16'h0000, 8'h01, 24'h000500);
        step();
        check("post_flush_pc", 64'(pc_e), 64'h000500);

        // Flush while a hazard would fire: no stall counted.
        dec(4'd1, 4'd1, 4'd9, 16'h0000, 8'h03, 24'h000600);
        step();
        dec(4'd2, 4'd9, 4'd1, 16'h0000, 8'h01, 24'h000604);
        flush = 1'b1;
        settle();
        check("flush_hz_hazard", 64'(hazard_o), 64'h0);
        tick();
        check("flush_hz_cnt", 64'(stall_cnt), 64'h1);
        flush = 1'b0;

        // Saturation: a load held under backpressure stalls five cycles.
        dec(4'd1, 4'd1, 4'd4, 16'h0000, 8'h03, 24'h000700);
        step();
        dec(4'd4, 4'd0, 4'd1, 16'h0000, 8'h01, 24'h000704);
        out_ready = 1'b0;
        repeat (5) begin
            settle();
            check("sat_hazard", 64'(hazard_o), 64'h1);
            tick();
        end
        check("sat_cnt", 64'(stall_cnt), 64'h3);
        out_ready = 1'b1;
        step();
        step();
        check("sat_issue_pc", 64'(pc_e), 64'h000704);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            in_valid   = ($urandom % 4) != 0;
            instr_d    = mk_instr(4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                                  4'($urandom_range(0, 7)), 16'($urandom));
            ctrl_d     = 8'($urandom);
            imm_signed = 1'($urandom);
            pc_d       = 24'($urandom);
            pcplus4_d  = pc_d + 24'd4;
            wb_we      = 1'($urandom);
            wb_addr    = 4'($urandom_range(0, 7));
            wb_data    = 24'($urandom);
            flush      = ($urandom % 12) == 0;
            out_ready  = ($urandom % 4) != 0;
            step();
        end

        // Asynchronous reset mid-operation clears state at once.
        idle();
        wb_we = 1'b1; wb_addr = 4'd3; wb_data = 24'h55AA55;
        dec(4'd1, 4'd2, 4'd3, 16'h1234, 8'h01, 24'h000800);
        step();
        wb_we = 1'b0;
        dec(4'd3, 4'd3, 4'd1, 16'h4321, 8'h01, 24'h000804);
        tick();
        #2;
        rst = 1'b1;
        m_reset();
        #1;
        check("async_rst_valid", 64'(out_valid), 64'h0);
        check("async_rst_pc", 64'(pc_e), 64'h0);
        check("async_rst_cnt", 64'(stall_cnt), 64'h0);
        check("async_rst_ready", 64'(in_ready), 64'h1);
        step();
        rst = 1'b0;
        dec(4'd3, 4'd3, 4'd1, 16'h0000, 8'h01, 24'h000900);
        step();
        check("rf_cleared_rd1", 64'(rd1_e), 64'h0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
